// File: rtl/npu_layer_sequencer.sv
// npu_layer_sequencer: steps the conv engine through up to MAX_LAYERS descriptors, ping-ponging
// activation buffers between layers. Define LAYER_TIMEOUT_EN to add a per-layer WAIT watchdog.
module npu_layer_sequencer #(
    parameter int              MAX_LAYERS  = 8,
    parameter int              LIDX_W      = 3,
    parameter int              ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BUF_A     = 16'h0000,
    parameter logic [ADDR_W-1:0] BUF_B     = 16'h8000,
    parameter logic [31:0]     TIMEOUT_CYC = 32'd2000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cfg_we,
    input  logic [LIDX_W-1:0] cfg_idx,
    input  logic [2:0]        cfg_k,
    input  logic [13:0]       cfg_ic,
    input  logic [5:0]        cfg_img_h,
    input  logic [5:0]        cfg_img_w,
    input  logic [7:0]        cfg_oc,
    input  logic [2:0]        cfg_stride,
    input  logic [3:0]        cfg_shift_n,
    input  logic [LIDX_W:0]   num_layers,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LIDX_W-1:0] err_layer,
    output logic              eng_start,
    input  logic              eng_done,
    output logic [2:0]        eng_k,
    output logic [13:0]       eng_ic,
    output logic [5:0]        eng_img_h,
    output logic [5:0]        eng_img_w,
    output logic [7:0]        eng_oc,
    output logic [2:0]        eng_stride,
    output logic [3:0]        eng_shift_n,
    output logic [ADDR_W-1:0] eng_in_base,
    output logic [ADDR_W-1:0] eng_out_base,
    output logic [LIDX_W-1:0] cur_layer,
    output logic [2:0]        fsm_state
);
    // Handshakes are single-cycle pulses: start is accepted only in IDLE (busy low), eng_start
    // is high for exactly the LAUNCH cycle, and eng_done is honoured only while in WAIT.
    typedef enum logic [2:0] {IDLE, CHECK, LAUNCH, WAIT, NEXT, FINISH} state_t;

    localparam logic [LIDX_W:0] MAX_N = (LIDX_W+1)'(MAX_LAYERS);

    state_t            state;
    logic [LIDX_W:0]   n_layers;
    logic [LIDX_W-1:0] idx;
    logic [LIDX_W:0]   idx_count;
    logic              desc_ok;

    logic [2:0]  d_k      [MAX_LAYERS];
    logic [13:0] d_ic     [MAX_LAYERS];
    logic [5:0]  d_img_h  [MAX_LAYERS];
    logic [5:0]  d_img_w  [MAX_LAYERS];
    logic [7:0]  d_oc     [MAX_LAYERS];
    logic [2:0]  d_stride [MAX_LAYERS];
    logic [3:0]  d_shift  [MAX_LAYERS];

`ifdef LAYER_TIMEOUT_EN
    logic [31:0] wait_cnt;
`endif

    assign fsm_state = state;
    assign idx_count = {1'b0, idx} + (LIDX_W+1)'(1);

    // busy is still low in the start cycle, so a same-cycle write lands before CHECK reads it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                d_k[i]      <= '0;
                d_ic[i]     <= '0;
                d_img_h[i]  <= '0;
                d_img_w[i]  <= '0;
                d_oc[i]     <= '0;
                d_stride[i] <= '0;
                d_shift[i]  <= '0;
            end
        end else if (cfg_we && !busy) begin
            d_k[cfg_idx]      <= cfg_k;
            d_ic[cfg_idx]     <= cfg_ic;
            d_img_h[cfg_idx]  <= cfg_img_h;
            d_img_w[cfg_idx]  <= cfg_img_w;
            d_oc[cfg_idx]     <= cfg_oc;
            d_stride[cfg_idx] <= cfg_stride;
            d_shift[cfg_idx]  <= cfg_shift_n;
        end
    end

    always_comb begin
        desc_ok = 1'b1;
        if (d_k[idx] == '0 || d_stride[idx] == '0 || d_ic[idx] == '0 || d_oc[idx] == '0)
            desc_ok = 1'b0;
        if ({3'b000, d_k[idx]} > d_img_h[idx] || {3'b000, d_k[idx]} > d_img_w[idx])
            desc_ok = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            n_layers     <= '0;
            idx          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_layer    <= '0;
            eng_start    <= 1'b0;
            eng_k        <= '0;
            eng_ic       <= '0;
            eng_img_h    <= '0;
            eng_img_w    <= '0;
            eng_oc       <= '0;
            eng_stride   <= '0;
            eng_shift_n  <= '0;
            cur_layer    <= '0;
            eng_in_base  <= BUF_A;
            eng_out_base <= BUF_B;
`ifdef LAYER_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            done      <= 1'b0;
            eng_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_layers     <= num_layers;
                        err          <= 1'b0;
                        idx          <= '0;
                        eng_in_base  <= BUF_A;
                        eng_out_base <= BUF_B;
                        busy         <= 1'b1;
                        state        <= CHECK;
                        if (num_layers == '0 || num_layers > MAX_N) begin
                            err       <= (num_layers != '0);
                            err_layer <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= FINISH;
                        end
                    end
                end
                CHECK: begin
                    cur_layer   <= idx;
                    eng_k       <= d_k[idx];
                    eng_ic      <= d_ic[idx];
                    eng_img_h   <= d_img_h[idx];
                    eng_img_w   <= d_img_w[idx];
                    eng_oc      <= d_oc[idx];
                    eng_stride  <= d_stride[idx];
                    eng_shift_n <= d_shift[idx];
                    if (desc_ok) begin
                        eng_start <= 1'b1;
                        state     <= LAUNCH;
                    end else begin
                        err       <= 1'b1;
                        err_layer <= idx;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FINISH;
                    end
                end
                LAUNCH: begin
`ifdef LAYER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        state <= NEXT;
`ifdef LAYER_TIMEOUT_EN
                    end else if (wait_cnt == TIMEOUT_CYC - 32'd1) begin
                        err       <= 1'b1;
                        err_layer <= idx;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
`endif
                    end
                end
                NEXT: begin
                    if (idx_count == n_layers) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        idx          <= idx + 1'b1;
                        eng_in_base  <= eng_out_base;
                        eng_out_base <= eng_in_base;
                        state        <= CHECK;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_npu_layer_sequencer.sv
// Self-checking bench for npu_layer_sequencer: engine model, event monitor and a descriptor-level
// reference model that predicts the launched layers, their buffers and the error outcome.
module tb_npu_layer_sequencer;
    localparam int          ML    = 8;
    localparam logic [15:0] BUF_A = 16'h0000;
    localparam logic [15:0] BUF_B = 16'h8000;

    typedef struct packed {
        logic [2:0] k; logic [13:0] ic; logic [5:0] h; logic [5:0] w;
        logic [7:0] oc; logic [2:0] stride; logic [3:0] shift;
    } desc_t;
    typedef struct packed {
        desc_t d; logic [15:0] inb; logic [15:0] outb; logic [2:0] layer;
    } rec_t;

    logic clk = 1'b0, resetn = 1'b0;
    logic cfg_we = 1'b0;
    logic [2:0] cfg_idx = '0, cfg_k = '0, cfg_stride = '0;
    logic [13:0] cfg_ic = '0;
    logic [5:0] cfg_img_h = '0, cfg_img_w = '0;
    logic [7:0] cfg_oc = '0;
    logic [3:0] cfg_shift_n = '0, num_layers = '0;
    logic start = 1'b0;
    logic busy, done, err, eng_start, eng_done;
    logic [2:0] err_layer, cur_layer, eng_k, eng_stride, fsm_state;
    logic [13:0] eng_ic;
    logic [5:0] eng_img_h, eng_img_w;
    logic [7:0] eng_oc;
    logic [3:0] eng_shift_n;
    logic [15:0] eng_in_base, eng_out_base;
    logic model_done = 1'b0, stray_done = 1'b0;
    assign eng_done = model_done | stray_done;

    int checks = 0, errors = 0, cyc = 0;
    int eng_delay = 20, gen = 0;
    bit eng_auto = 1'b1;
    desc_t mtab [ML];
    rec_t obs_q[$], exp_q[$];
    int start_cyc_q[$], done_cyc_q[$], edone_cyc_q[$];
    bit exp_err;
    int exp_err_layer;

    npu_layer_sequencer #(.TIMEOUT_CYC(32'd100)) dut (
        .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_k(cfg_k),
        .cfg_ic(cfg_ic), .cfg_img_h(cfg_img_h), .cfg_img_w(cfg_img_w), .cfg_oc(cfg_oc),
        .cfg_stride(cfg_stride), .cfg_shift_n(cfg_shift_n), .num_layers(num_layers),
        .start(start), .busy(busy), .done(done), .err(err), .err_layer(err_layer),
        .eng_start(eng_start), .eng_done(eng_done), .eng_k(eng_k), .eng_ic(eng_ic),
        .eng_img_h(eng_img_h), .eng_img_w(eng_img_w), .eng_oc(eng_oc), .eng_stride(eng_stride),
        .eng_shift_n(eng_shift_n), .eng_in_base(eng_in_base), .eng_out_base(eng_out_base),
        .cur_layer(cur_layer), .fsm_state(fsm_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        rec_t r;
        if (resetn) begin
            if (eng_start) begin
                r = '{d: '{k: eng_k, ic: eng_ic, h: eng_img_h, w: eng_img_w, oc: eng_oc,
                           stride: eng_stride, shift: eng_shift_n},
                      inb: eng_in_base, outb: eng_out_base, layer: cur_layer};
                obs_q.push_back(r);
                start_cyc_q.push_back(cyc);
            end
            if (done) done_cyc_q.push_back(cyc);
        end
    end

    // ---------------- engine model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (eng_start && eng_auto) begin : rsp
                int g;
                g = gen;
                repeat (eng_delay) @(posedge clk);
                if (g == gen) begin
                    #1 model_done = 1'b1;
                    @(negedge clk) edone_cyc_q.push_back(cyc);
                    @(posedge clk) #1 model_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit desc_valid(input desc_t d);
        return d.k != 0 && d.stride != 0 && d.ic != 0 && d.oc != 0 && d.k <= d.h && d.k <= d.w;
    endfunction

    task automatic build_expect(input int n);
        rec_t r;
        exp_q.delete();
        exp_err = 1'b0;
        exp_err_layer = 0;
        if (n > ML) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (!desc_valid(mtab[i])) begin
                exp_err = 1'b1;
                exp_err_layer = i;
                return;
            end
            r.d = mtab[i];
            r.inb = (i % 2 == 0) ? BUF_A : BUF_B;
            r.outb = (i % 2 == 0) ? BUF_B : BUF_A;
            r.layer = 3'(i);
            exp_q.push_back(r);
        end
    endtask

    function automatic desc_t rand_desc(input bit valid);
        desc_t d;
        d.k = 3'($urandom_range(1, 7));
        d.h = 6'($urandom_range(63, int'(d.k)));
        d.w = 6'($urandom_range(63, int'(d.k)));
        d.ic = 14'($urandom_range(1, 16383));
        d.oc = 8'($urandom_range(1, 255));
        d.stride = 3'($urandom_range(1, 7));
        d.shift = 4'($urandom);
        if (!valid) begin
            case ($urandom_range(0, 5))
                0: d.k = '0;
                1: d.stride = '0;
                2: d.ic = '0;
                3: d.oc = '0;
                4: d.h = 6'(d.k - 3'd1);
                default: d.w = 6'(d.k - 3'd1);
            endcase
        end
        return d;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_cfg(input int i, input desc_t d);
        cfg_idx = 3'(i); cfg_k = d.k; cfg_ic = d.ic; cfg_img_h = d.h; cfg_img_w = d.w;
        cfg_oc = d.oc; cfg_stride = d.stride; cfg_shift_n = d.shift;
    endtask

    task automatic write_desc(input int i, input desc_t d);
        @(posedge clk); #1;
        cfg_we = 1'b1;
        drive_cfg(i, d);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        mtab[i] = d;
    endtask

    task automatic clear_obs();
        obs_q.delete(); start_cyc_q.delete(); done_cyc_q.delete(); edone_cyc_q.delete();
    endtask

    task automatic run(input int n, input bit with_wr, input int wi, input desc_t wd,
                       input bit stray_chk, input int budget, output bit ok, output int s);
        clear_obs();
        @(posedge clk); #1;
        start = 1'b1;
        num_layers = 4'(n);
        if (with_wr) begin
            cfg_we = 1'b1;
            drive_cfg(wi, wd);
            mtab[wi] = wd;
        end
        @(negedge clk) s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_we = 1'b0;
        stray_done = stray_chk;
        @(posedge clk); #1;
        stray_done = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (done_cyc_q.size() > 0) ok = 1'b1;
        end
        repeat (4) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < ML; i++) mtab[i] = '0;
        @(negedge clk);
        checks++; if ({busy, done, err, eng_start} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, err, eng_start}); end
        checks++; if (eng_in_base !== BUF_A || eng_out_base !== BUF_B) begin errors++;
            $display("FAIL reset_bases: got %h/%h expected %h/%h", eng_in_base, eng_out_base, BUF_A, BUF_B); end
        checks++; if ({eng_k, eng_ic, eng_img_h, eng_img_w, eng_oc, eng_stride, eng_shift_n} !== '0) begin errors++;
            $display("FAIL reset_eng_cfg: got k=%0d ic=%0d oc=%0d expected all zero", eng_k, eng_ic, eng_oc); end
        checks++; if (cur_layer !== 3'd0 || err_layer !== 3'd0) begin errors++;
            $display("FAIL reset_layer: got cur=%0d err_layer=%0d expected 0/0", cur_layer, err_layer); end
    endtask

    task automatic test_single_layer();
        desc_t d; rec_t r; bit ok; int s;
        d = '{k: 3'd3, ic: 14'd8, h: 6'd32, w: 6'd32, oc: 8'd16, stride: 3'd1, shift: 4'd8};
        write_desc(0, d);
        eng_delay = 50;
        run(1, 1'b0, 0, d, 1'b0, 500, ok, s);
        r = '{d: d, inb: BUF_A, outb: BUF_B, layer: 3'd0};
        checks++; if (!ok) begin errors++; $display("FAIL single_done_seen: got none expected done"); end
        checks++; if (obs_q.size() != 1) begin errors++;
            $display("FAIL single_start_count: got %0d expected 1", obs_q.size()); end
        checks++; if (obs_q.size() != 1 || start_cyc_q[0] != s + 2) begin errors++;
            $display("FAIL single_start_latency: got %0d expected 2", obs_q.size() == 1 ? start_cyc_q[0] - s : -1); end
        checks++; if (obs_q.size() != 1 || obs_q[0] !== r) begin errors++;
            $display("FAIL single_cfg: got %h expected %h", obs_q.size() == 1 ? obs_q[0] : '0, r); end
        checks++; if (done_cyc_q.size() != 1 || edone_cyc_q.size() != 1 || done_cyc_q[0] != edone_cyc_q[0] + 2) begin errors++;
            $display("FAIL single_done_latency: got %0d pulses expected one pulse 2 cycles after eng_done", done_cyc_q.size()); end
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL single_end_flags: got err=%b busy=%b expected 0/0", err, busy); end
    endtask

    task automatic test_three_layers();
        rec_t r; bit ok; int s;
        for (int i = 0; i < 3; i++) write_desc(i, rand_desc(1'b1));
        eng_delay = 20;
        run(3, 1'b0, 0, '0, 1'b0, 500, ok, s);
        checks++; if (!ok || obs_q.size() != 3 || done_cyc_q.size() != 1) begin errors++;
            $display("FAIL three_counts: got starts=%0d dones=%0d expected 3/1", obs_q.size(), done_cyc_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            r = '{d: mtab[i], inb: (i == 1) ? BUF_B : BUF_A, outb: (i == 1) ? BUF_A : BUF_B, layer: 3'(i)};
            checks++; if (obs_q[i] !== r) begin errors++;
                $display("FAIL three_layer%0d: got %h expected %h", i, obs_q[i], r); end
            if (i > 0) begin
                checks++; if (start_cyc_q[i] != edone_cyc_q[i-1] + 3) begin errors++;
                    $display("FAIL three_gap%0d: got %0d expected 3", i, start_cyc_q[i] - edone_cyc_q[i-1]); end
            end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL three_err: got %b expected 0", err); end
    endtask

    task automatic test_validation();
        desc_t d1; bit ok; int s;
        write_desc(0, rand_desc(1'b1));
        d1 = '{k: 3'd5, ic: 14'd8, h: 6'd32, w: 6'd4, oc: 8'd16, stride: 3'd1, shift: 4'd8};
        write_desc(1, d1);
        run(2, 1'b0, 0, '0, 1'b0, 500, ok, s);
        checks++; if (!ok || obs_q.size() != 1 || done_cyc_q.size() != 1) begin errors++;
            $display("FAIL valid_counts: got starts=%0d dones=%0d expected 1/1", obs_q.size(), done_cyc_q.size()); end
        checks++; if (err !== 1'b1 || err_layer !== 3'd1) begin errors++;
            $display("FAIL valid_err: got err=%b layer=%0d expected 1/1", err, err_layer); end
        checks++; if (edone_cyc_q.size() != 1 || done_cyc_q.size() != 1 || done_cyc_q[0] != edone_cyc_q[0] + 3) begin errors++;
            $display("FAIL valid_done_latency: got %0d dones expected one 3 cycles after eng_done", done_cyc_q.size()); end
    endtask

    task automatic test_num_layers_edges();
        bit ok; int s; int n;
        run(0, 1'b0, 0, '0, 1'b0, 20, ok, s);
        checks++; if (!ok || obs_q.size() != 0 || done_cyc_q.size() != 1 || err !== 1'b0) begin errors++;
            $display("FAIL zero_layers: got starts=%0d dones=%0d err=%b expected 0/1/0", obs_q.size(), done_cyc_q.size(), err); end
        checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] < s + 1 || done_cyc_q[0] > s + 2) begin errors++;
            $display("FAIL zero_latency: got %0d expected 1..2", done_cyc_q.size() == 1 ? done_cyc_q[0] - s : -1); end
        for (int t = 0; t < 3; t++) begin
            n = (t == 0) ? 15 : $urandom_range(9, 14);
            run(n, 1'b0, 0, '0, 1'b0, 20, ok, s);
            checks++; if (!ok || obs_q.size() != 0 || done_cyc_q.size() != 1) begin errors++;
                $display("FAIL too_many_n%0d: got starts=%0d dones=%0d expected 0/1", n, obs_q.size(), done_cyc_q.size()); end
            checks++; if (err !== 1'b1 || err_layer !== 3'd0) begin errors++;
                $display("FAIL too_many_err_n%0d: got err=%b layer=%0d expected 1/0", n, err, err_layer); end
        end
    endtask

    task automatic test_ignored_inputs();
        desc_t d, dk1; bit ok; int s;
        d = '{k: 3'd3, ic: 14'd8, h: 6'd32, w: 6'd32, oc: 8'd16, stride: 3'd1, shift: 4'd8};
        write_desc(0, d);
        eng_delay = 40;
        clear_obs();
        @(posedge clk); #1 start = 1'b1; num_layers = 4'd1;
        @(posedge clk); #1 start = 1'b0;
        repeat (15) @(posedge clk); #1;
        dk1 = d; dk1.k = 3'd1;
        start = 1'b1; num_layers = 4'd3; cfg_we = 1'b1; drive_cfg(0, dk1);
        @(posedge clk); #1 start = 1'b0; cfg_we = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin @(negedge clk); if (done_cyc_q.size() > 0) ok = 1'b1; end
        repeat (6) @(negedge clk);
        checks++; if (!ok || obs_q.size() != 1 || done_cyc_q.size() != 1) begin errors++;
            $display("FAIL busy_start_ignored: got starts=%0d dones=%0d expected 1/1", obs_q.size(), done_cyc_q.size()); end
        run(1, 1'b0, 0, '0, 1'b0, 200, ok, s);
        checks++; if (obs_q.size() != 1 || obs_q[0].d !== mtab[0]) begin errors++;
            $display("FAIL busy_write_ignored: got k=%0d expected k=%0d", obs_q.size() == 1 ? obs_q[0].d.k : 3'd0, mtab[0].k); end
        clear_obs();
        @(posedge clk); #1 stray_done = 1'b1;
        @(posedge clk); #1 stray_done = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (obs_q.size() != 0 || done_cyc_q.size() != 0 || busy !== 1'b0) begin errors++;
            $display("FAIL stray_idle: got starts=%0d dones=%0d busy=%b expected 0/0/0", obs_q.size(), done_cyc_q.size(), busy); end
        run(1, 1'b0, 0, '0, 1'b1, 200, ok, s);
        checks++; if (!ok || obs_q.size() != 1 || start_cyc_q[0] != s + 2) begin errors++;
            $display("FAIL stray_check_start: got starts=%0d expected 1 at +2", obs_q.size()); end
        checks++; if (edone_cyc_q.size() != 1 || done_cyc_q.size() != 1 || done_cyc_q[0] != edone_cyc_q[0] + 2) begin errors++;
            $display("FAIL stray_check_done: got dones=%0d expected one 2 cycles after eng_done", done_cyc_q.size()); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok; int s;
        for (int i = 0; i < 3; i++) write_desc(i, rand_desc(1'b1));
        eng_delay = 40;
        clear_obs();
        @(posedge clk); #1 start = 1'b1; num_layers = 4'd3;
        @(posedge clk); #1 start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin @(negedge clk); if (start_cyc_q.size() == 2) ok = 1'b1; end
        repeat (10) @(negedge clk);
        @(posedge clk); #1 resetn = 1'b0; gen++;
        #1;
        checks++; if (!ok || busy !== 1'b0) begin errors++;
            $display("FAIL reset_async_busy: got busy=%b reached_layer1=%b expected 0/1", busy, ok); end
        #49 resetn = 1'b1;
        for (int i = 0; i < ML; i++) mtab[i] = '0;
        repeat (50) @(negedge clk);
        checks++; if (done_cyc_q.size() != 0 || busy !== 1'b0 || eng_in_base !== BUF_A || eng_out_base !== BUF_B) begin errors++;
            $display("FAIL reset_mid_wait: got dones=%0d busy=%b bases=%h/%h expected 0/0/%h/%h",
                     done_cyc_q.size(), busy, eng_in_base, eng_out_base, BUF_A, BUF_B); end
        checks++; if (cur_layer !== 3'd0 || eng_k !== 3'd0) begin errors++;
            $display("FAIL reset_mid_wait_cfg: got cur=%0d k=%0d expected 0/0", cur_layer, eng_k); end
        write_desc(0, rand_desc(1'b1));
        eng_delay = 10;
        run(1, 1'b0, 0, '0, 1'b0, 200, ok, s);
        checks++; if (!ok || obs_q.size() != 1 || obs_q[0].d !== mtab[0] || err !== 1'b0) begin errors++;
            $display("FAIL reset_rerun: got starts=%0d err=%b expected 1/0", obs_q.size(), err); end
    endtask

    task automatic test_random_runs();
        bit ok, with_wr; int s, n, wi, exp_dc; desc_t wd;
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < ML; i++)
                if (it == 0 || $urandom_range(0, 2) == 0) write_desc(i, rand_desc($urandom_range(0, 6) != 0));
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, ML);
            with_wr = 1'($urandom_range(0, 1));
            wi = $urandom_range(0, ML - 1);
            wd = rand_desc($urandom_range(0, 4) != 0);
            eng_delay = $urandom_range(1, 30);
            run(n, with_wr, wi, wd, 1'b0, 2000, ok, s);
            build_expect(n);
            checks++; if (!ok || done_cyc_q.size() != 1) begin errors++;
                $display("FAIL rand%0d_done_count: got %0d expected 1", it, done_cyc_q.size()); end
            checks++; if (obs_q.size() != exp_q.size()) begin errors++;
                $display("FAIL rand%0d_start_count: got %0d expected %0d (n=%0d)", it, obs_q.size(), exp_q.size(), n); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin errors++;
                    $display("FAIL rand%0d_layer%0d: got %h expected %h", it, i, obs_q[i], exp_q[i]); end
                checks++; if (start_cyc_q[i] != ((i == 0) ? s + 2 : edone_cyc_q[i-1] + 3)) begin errors++;
                    $display("FAIL rand%0d_start_time%0d: got cycle %0d", it, i, start_cyc_q[i]); end
            end
            checks++; if (err !== exp_err || (exp_err && err_layer !== 3'(exp_err_layer))) begin errors++;
                $display("FAIL rand%0d_err: got err=%b layer=%0d expected %b/%0d", it, err, err_layer, exp_err, exp_err_layer); end
            if (n == 0 || n > ML) exp_dc = -1;
            else if (!exp_err) exp_dc = (edone_cyc_q.size() == n) ? edone_cyc_q[n-1] + 2 : -2;
            else if (exp_err_layer == 0) exp_dc = s + 2;
            else exp_dc = (edone_cyc_q.size() == exp_err_layer) ? edone_cyc_q[exp_err_layer-1] + 3 : -2;
            if (exp_dc != -1) begin
                checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != exp_dc) begin errors++;
                    $display("FAIL rand%0d_done_time: got %0d expected %0d", it,
                             done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, exp_dc); end
            end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_busy: got 1 expected 0", it); end
        end
    endtask

`ifdef LAYER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok; int s;
        write_desc(0, rand_desc(1'b1));
        write_desc(1, rand_desc(1'b1));
        eng_auto = 1'b0;
        run(2, 1'b0, 0, '0, 1'b0, 400, ok, s);
        checks++; if (!ok || obs_q.size() != 1 || err !== 1'b1 || err_layer !== 3'd0) begin errors++;
            $display("FAIL timeout_err: got starts=%0d err=%b layer=%0d expected 1/1/0", obs_q.size(), err, err_layer); end
        checks++; if (done_cyc_q.size() != 1 || obs_q.size() != 1 || done_cyc_q[0] - start_cyc_q[0] < 95 || done_cyc_q[0] - start_cyc_q[0] > 110) begin errors++;
            $display("FAIL timeout_latency: got %0d expected about 102", done_cyc_q.size() == 1 ? done_cyc_q[0] - s - 2 : -1); end
        clear_obs();
        @(posedge clk); #1 stray_done = 1'b1;
        @(posedge clk); #1 stray_done = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (done_cyc_q.size() != 0 || obs_q.size() != 0 || busy !== 1'b0) begin errors++;
            $display("FAIL timeout_late_done: got dones=%0d starts=%0d expected 0/0", done_cyc_q.size(), obs_q.size()); end
        eng_auto = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_layer();
        test_three_layers();
        test_validation();
        test_num_layers_edges();
        test_ignored_inputs();
        test_reset_mid_wait();
        test_random_runs();
`ifdef LAYER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
